lcd_hd44780_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_phase_timer.sv | 35 +++
 rtl/lcd_hd44780_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// Module      : lcd_pkg
// Description : Shared state encoding, command constants and helpers for the
//               HD44780 4-bit bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [3:0] {
        ST_PWRON = 4'd0,
        ST_IDLE  = 4'd1,
        ST_SET_H = 4'd2,
        ST_EH_H  = 4'd3,
        ST_HLD_H = 4'd4,
        ST_SET_L = 4'd5,
        ST_EH_L  = 4'd6,
        ST_HLD_L = 4'd7,
        ST_EXEC  = 4'd8
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait; 0x00 is
    // lumped in because it shares the same upper seven bits as clear.
    function automatic logic is_long_cmd(input logic rs, input logic nib,
                                         input logic [7:0] data);
        return !rs && !nib &&
               ((data[7:1] == LCD_CMD_CLEAR[7:1]) ||
                (data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_phase_timer.sv
// ============================================================================
// Module      : lcd_phase_timer
// Description : Loadable down-counter that holds at zero; times every phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_phase_timer #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_hd44780_ctrl.sv
// ============================================================================
// Module      : lcd_hd44780_ctrl
// Description : HD44780 4-bit write sequencer with power-on wait, busy,
//               overrun flag and backlight register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int E_HIGH_CYC    = 13,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 1100,
    parameter int EXEC_LONG_CYC = 44000,
    parameter int POWERON_CYC   = 1100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_rs,
    input  logic       wr_nib,
    input  logic [7:0] wr_data,
    input  logic       bl_wen,
    input  logic       bl_val,
    input  logic       ovr_clr,
    output logic       busy,
    output logic       overrun,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       lcd_bl,
    output logic [3:0] lcd_db
);

    localparam int c_MAX_0 = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int c_MAX_1 = (c_MAX_0 > HOLD_CYC) ? c_MAX_0 : HOLD_CYC;
    localparam int c_MAX_2 = (c_MAX_1 > EXEC_CYC) ? c_MAX_1 : EXEC_CYC;
    localparam int c_MAX_3 = (c_MAX_2 > EXEC_LONG_CYC) ? c_MAX_2 : EXEC_LONG_CYC;
    localparam int c_MAX   = (c_MAX_3 > POWERON_CYC) ? c_MAX_3 : POWERON_CYC;
    localparam int c_CW    = $clog2(c_MAX) + 1;

    localparam logic [c_CW-1:0] c_LD_SETUP = c_CW'(SETUP_CYC - 1);
    localparam logic [c_CW-1:0] c_LD_EHIGH = c_CW'(E_HIGH_CYC - 1);
    localparam logic [c_CW-1:0] c_LD_HOLD  = c_CW'(HOLD_CYC - 1);
    localparam logic [c_CW-1:0] c_LD_EXEC  = c_CW'(EXEC_CYC - 1);
    localparam logic [c_CW-1:0] c_LD_LONG  = c_CW'(EXEC_LONG_CYC - 1);
    localparam logic [c_CW-1:0] c_LD_PWRON = c_CW'(POWERON_CYC - 1);

    lcd_state_t      r_state;
    lcd_state_t      w_next;
    logic            w_load;
    logic [c_CW-1:0] w_load_val;
    logic            w_zero;
    logic            w_busy;
    logic            w_accept;

    logic [7:0]      r_data;
    logic            r_nib;
    logic            r_long;
    logic            r_e;
    logic            r_rs;
    logic [3:0]      r_db;
    logic            r_bl;
    logic            r_ovr;

    lcd_phase_timer #(
        .WIDTH   (c_CW),
        .RST_VAL (c_LD_PWRON)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    assign w_busy   = (r_state != ST_IDLE);
    assign w_accept = (r_state == ST_IDLE) && wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PWRON;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = c_LD_SETUP;
        unique case (r_state)
            ST_PWRON: if (w_zero) w_next = ST_IDLE;
            ST_IDLE:  if (wr_en) begin
                w_next = ST_SET_H;  w_load = 1'b1;  w_load_val = c_LD_SETUP;
            end
            ST_SET_H: if (w_zero) begin
                w_next = ST_EH_H;   w_load = 1'b1;  w_load_val = c_LD_EHIGH;
            end
            ST_EH_H:  if (w_zero) begin
                w_next = ST_HLD_H;  w_load = 1'b1;  w_load_val = c_LD_HOLD;
            end
            // A lone nibble skips the low half and goes straight to execution.
            ST_HLD_H: if (w_zero) begin
                w_load = 1'b1;
                if (r_nib) begin
                    w_next     = ST_EXEC;
                    w_load_val = r_long ? c_LD_LONG : c_LD_EXEC;
                end else begin
                    w_next     = ST_SET_L;
                    w_load_val = c_LD_SETUP;
                end
            end
            ST_SET_L: if (w_zero) begin
                w_next = ST_EH_L;   w_load = 1'b1;  w_load_val = c_LD_EHIGH;
            end
            ST_EH_L:  if (w_zero) begin
                w_next = ST_HLD_L;  w_load = 1'b1;  w_load_val = c_LD_HOLD;
            end
            ST_HLD_L: if (w_zero) begin
                w_next     = ST_EXEC;
                w_load     = 1'b1;
                w_load_val = r_long ? c_LD_LONG : c_LD_EXEC;
            end
            ST_EXEC:  if (w_zero) w_next = ST_IDLE;
            default:  w_next = ST_PWRON;
        endcase
    end

    // Bus outputs are registered so E and DB never glitch on state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 8'h00;
            r_nib  <= 1'b0;
            r_long <= 1'b0;
            r_e    <= 1'b0;
            r_rs   <= 1'b0;
            r_db   <= 4'h0;
            r_bl   <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_e <= (w_next == ST_EH_H) || (w_next == ST_EH_L);
            if (w_accept) begin
                r_data <= wr_data;
                r_nib  <= wr_nib;
                r_long <= is_long_cmd(wr_rs, wr_nib, wr_data);
                r_rs   <= wr_rs;
                r_db   <= wr_data[7:4];
            end else if (w_next == ST_SET_L && r_state == ST_HLD_H) begin
                r_db <= r_data[3:0];
            end
            if (bl_wen) begin
                r_bl <= bl_val;
            end
            r_ovr <= (wr_en && w_busy) || (r_ovr && !ovr_clr);
        end
    end

    assign busy    = w_busy;
    assign overrun = r_ovr;
    assign lcd_e   = r_e;
    assign lcd_rw  = 1'b0;
    assign lcd_rs  = r_rs;
    assign lcd_bl  = r_bl;
    assign lcd_db  = r_db;

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
// ============================================================================
// Module      : tb_lcd_hd44780_ctrl
// Description : Scoreboard bench for the HD44780 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_hd44780_ctrl;

    localparam int c_SETUP = 2;
    localparam int c_EHIGH = 3;
    localparam int c_HOLD  = 2;
    localparam int c_EXEC  = 5;
    localparam int c_LONG  = 20;
    localparam int c_PWRON = 10;
    localparam int c_XFER  = c_SETUP + c_EHIGH + c_HOLD;

    typedef struct packed {
        logic [3:0] db;
        logic       rs;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, wr_rs = 1'b0, wr_nib = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       bl_wen = 1'b0, bl_val = 1'b0, ovr_clr = 1'b0;
    logic       busy, overrun, lcd_e, lcd_rw, lcd_rs, lcd_bl;
    logic [3:0] lcd_db;

    int     n_pass = 0;
    int     n_total = 0;
    int     exp_busy[$];
    pulse_t exp_pulse[$];

    lcd_hd44780_ctrl #(
        .SETUP_CYC     (c_SETUP),
        .E_HIGH_CYC    (c_EHIGH),
        .HOLD_CYC      (c_HOLD),
        .EXEC_CYC      (c_EXEC),
        .EXEC_LONG_CYC (c_LONG),
        .POWERON_CYC   (c_PWRON)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_rs   (wr_rs),
        .wr_nib  (wr_nib),
        .wr_data (wr_data),
        .bl_wen  (bl_wen),
        .bl_val  (bl_val),
        .ovr_clr (ovr_clr),
        .busy    (busy),
        .overrun (overrun),
        .lcd_e   (lcd_e),
        .lcd_rw  (lcd_rw),
        .lcd_rs  (lcd_rs),
        .lcd_bl  (lcd_bl),
        .lcd_db  (lcd_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected busy length and E pulses for one request, from the request alone.
    task automatic push_req(input logic rs, input logic nib, input logic [7:0] data);
        logic long_cmd;
        long_cmd = !rs && !nib && (data[7:2] == 6'd0);
        exp_busy.push_back((nib ? c_XFER : 2 * c_XFER) + (long_cmd ? c_LONG : c_EXEC));
        exp_pulse.push_back('{db: data[7:4], rs: rs});
        if (!nib) exp_pulse.push_back('{db: data[3:0], rs: rs});
    endtask

    task automatic send(input logic rs, input logic nib, input logic [7:0] data);
        push_req(rs, nib, data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_rs = rs; wr_nib = nib; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_busy.push_back(c_PWRON);
    endtask

    // Scoreboard monitor: measures busy runs and E pulses on the falling edge.
    int         busy_cnt = 0, e_cnt = 0;
    logic       busy_prev = 1'b1, e_prev = 1'b0;
    logic [3:0] e_db;
    logic       e_rs;
    pulse_t     p;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0; e_cnt = 0; busy_prev = 1'b1; e_prev = 1'b0;
            exp_busy.delete();
            exp_pulse.delete();
        end else begin
            if (busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (exp_busy.size() == 0) check("busy_unexpected", busy_cnt, 0);
                else check("busy_len", busy_cnt, exp_busy.pop_front());
                busy_cnt = 0;
            end
            busy_prev = busy;
            if (lcd_e) begin
                if (!e_prev) begin
                    e_db = lcd_db; e_rs = lcd_rs; e_cnt = 0;
                end
                e_cnt++;
            end else if (e_prev) begin
                if (exp_pulse.size() == 0) begin
                    check("pulse_unexpected", 1, 0);
                end else begin
                    p = exp_pulse.pop_front();
                    check("pulse_db", e_db, p.db);
                    check("pulse_rs", e_rs, p.rs);
                    check("pulse_len", e_cnt, c_EHIGH);
                    check("hold_db", lcd_db, p.db);
                end
            end
            e_prev = lcd_e;
            if (lcd_rw !== 1'b0) check("rw_zero", lcd_rw, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on: outputs quiet for the whole wait.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_e", lcd_e, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        exp_busy.push_back(c_PWRON);
        for (int i = 0; i < c_PWRON; i++) begin
            @(negedge clk);
            check("pwron_out", {lcd_e, lcd_rw, lcd_rs, lcd_bl, lcd_db}, 0);
        end
        wait_idle();

        send(1'b1, 1'b0, 8'h41);
        check("rs_during", lcd_rs, 1);
        wait_idle();
        send(1'b0, 1'b1, 8'h30);
        wait_idle();
        send(1'b0, 1'b0, 8'h01);  wait_idle();
        send(1'b0, 1'b0, 8'h03);  wait_idle();
        send(1'b0, 1'b0, 8'h06);  wait_idle();
        send(1'b0, 1'b0, 8'h04);  wait_idle();
        send(1'b0, 1'b0, 8'h00);  wait_idle();
        send(1'b0, 1'b1, 8'h00);  wait_idle();

        // Overrun during a transfer, then set-beats-clear, then clear.
        send(1'b1, 1'b0, 8'h41);
        repeat (4) @(posedge clk);
        #1;
        check("ovr_pre", overrun, 0);
        wr_en = 1'b1; wr_rs = 1'b0; wr_nib = 1'b1; wr_data = 8'h55;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("ovr_set", overrun, 1);
        wr_en = 1'b1; ovr_clr = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("ovr_set_wins", overrun, 1);
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        wait_idle();

        // Backlight write during EH_L leaves transfer timing intact.
        send(1'b1, 1'b0, 8'h41);
        repeat (9) @(posedge clk);
        #1;
        bl_wen = 1'b1; bl_val = 1'b1;
        check("bl_pre", lcd_bl, 0);
        @(posedge clk); #1;
        bl_wen = 1'b0;
        check("bl_on", lcd_bl, 1);
        check("bl_e_high", lcd_e, 1);
        wait_idle();

        // Reset in EH_L abandons the transfer and restarts the power-on wait.
        send(1'b1, 1'b0, 8'h41);
        repeat (10) @(posedge clk);
        #1;
        check("e_before_rst", lcd_e, 1);
        rst = 1'b1;
        #1;
        check("rst_async_e", lcd_e, 0);
        check("rst_async_bl", lcd_bl, 0);
        check("rst_async_db", lcd_db, 0);
        check("rst_async_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_busy.push_back(c_PWRON);
        repeat (3) @(posedge clk);
        #1;
        wr_en = 1'b1; wr_rs = 1'b1; wr_data = 8'h77; wr_nib = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("ovr_pwron", overrun, 1);
        wait_idle();

        do_reset();
        wait_idle();
        send(1'b1, 1'b0, 8'hA5);
        wait_idle();

        check("sb_empty", exp_busy.size() + exp_pulse.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
